// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone types, opcodes and default widths
package wb_pkg;

    localparam int WB_ADDR_WIDTH     = 16;
    localparam int WB_DATA_WIDTH     = 32;
    localparam int WB_GRANULE        = 8;
    localparam int WB_TIMEOUT_CYCLES = 16;

    localparam logic OP_CLASSIC_SINGLE_READ  = 1'b0;
    localparam logic OP_CLASSIC_SINGLE_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_master_state_e;

    // Counter width able to hold TIMEOUT_CYCLES-1; never narrower than one bit.
    function automatic int unsigned wb_cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/wb_master_classic_if.sv
// rtl/wb_master_classic_if.sv - Wishbone classic bus signals with master/slave views
interface wb_master_classic_if
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int SEL_WIDTH  = WB_DATA_WIDTH / WB_GRANULE
) ();

    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [SEL_WIDTH-1:0]  sel_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  ack_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output dat_i, ack_i
    );

endinterface

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - counts enabled cycles, flags the last one before abort
module wb_timeout_counter
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = wb_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && ENABLED) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted during the cycle whose closing edge would be the TIMEOUT_CYCLES-th without ACK.
    assign expired_o = ENABLED && enable_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_master_classic.sv
// rtl/wb_master_classic.sv - command/response stream to one Wishbone classic single cycle
module wb_master_classic
    import wb_pkg::*;
#(
    parameter  int          ADDR_WIDTH     = WB_ADDR_WIDTH,
    parameter  int          DATA_WIDTH     = WB_DATA_WIDTH,
    parameter  int          GRANULE        = WB_GRANULE,
    localparam int          SEL_WIDTH      = DATA_WIDTH / GRANULE,
    parameter  int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,

    wb_master_classic_if.master   wb
);

    wb_master_state_e      state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;

    logic in_bus;
    logic expired;

    assign in_bus = (state_q == BUS);

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!in_bus),
        .enable_i  (in_bus && !wb.ack_i),
        .expired_o (expired)
    );

    assign cmd_ready_o = (state_q == IDLE) && !rsp_valid_q;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    sel_d   = cmd_sel_i;
                    dat_d   = cmd_dat_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ACK is tested first so an ACK on the timeout edge completes normally.
                if (wb.ack_i) begin
                    rsp_dat_d   = (we_q == OP_CLASSIC_SINGLE_WRITE) ? '0 : wb.dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    state_d     = RESP;
                end else if (expired) begin
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    assign wb.cyc_o    = cyc_q;
    assign wb.stb_o    = stb_q;
    assign wb.we_o     = we_q;
    assign wb.adr_o    = adr_q;
    assign wb.sel_o    = sel_q;
    assign wb.dat_o    = dat_q;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;

endmodule
